// File: rtl/dbus_arbiter_pkg.sv
// dbus_arbiter shared types: FSM state encoding and arbitration mode codes.
// Imported by the arbiter top and its request picker.
package dbus_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_WAIT  = 2'd2,
        ARB_RESP  = 2'd3
    } arb_state_e;

    localparam int ARB_RR    = 0;
    localparam int ARB_FIXED = 1;

    localparam int CNT_W = 4;

    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

endpackage

// File: rtl/dbus_arbiter_rr_pick2.sv
// rr_pick2: combinational two-way request picker.
// mode=0 favours the master not served last; mode=1 always favours master 0.
module rr_pick2
    import dbus_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    input  logic       mode,
    output logic       valid,
    output logic       sel
);

    always_comb begin
        valid = |req;
        sel   = M0;
        case (req)
            2'b01:   sel = M0;
            2'b10:   sel = M1;
            2'b11:   sel = mode ? M0 : ~last;
            default: sel = M0;
        endcase
    end

endmodule

// File: rtl/dbus_arbiter.sv
// dbus_arbiter: two-master arbiter in front of the peripheral bridge data port.
// One transaction in flight at a time; reads wait RD_LAT cycles for bus_rdata.
module dbus_arbiter
    import dbus_arbiter_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int RD_LAT   = 1,
    parameter int ARB_MODE = 0
) (
    input  logic              cpu_clk,
    input  logic              cpu_rst,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              bus_en,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic [DATA_W-1:0] bus_rdata,
    output logic              busy
);

    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(RD_LAT - 1);

    arb_state_e        state_q, state_d;
    logic              owner_q, owner_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              last_q, last_d;
    logic [DATA_W-1:0] rdata0_q, rdata1_q;
    logic              cap_en;

    logic pick_valid;
    logic pick_sel;
    logic pick_mode;

    assign pick_mode = (ARB_MODE == ARB_FIXED);

    rr_pick2 u_pick (
        .req   ({m1_req, m0_req}),
        .last  (last_q),
        .mode  (pick_mode),
        .valid (pick_valid),
        .sel   (pick_sel)
    );

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        cap_en  = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                if (pick_valid) begin
                    owner_d = pick_sel;
                    we_d    = pick_sel ? m1_we    : m0_we;
                    addr_d  = pick_sel ? m1_addr  : m0_addr;
                    wdata_d = pick_sel ? m1_wdata : m0_wdata;
                    state_d = ARB_ISSUE;
                end
            end
            ARB_ISSUE: begin
                if (we_q) begin
                    last_d  = owner_q;
                    state_d = ARB_IDLE;
                end else begin
                    cnt_d   = CNT_INIT;
                    state_d = ARB_WAIT;
                end
            end
            ARB_WAIT: begin
                if (cnt_q == '0) begin
                    cap_en  = 1'b1;
                    state_d = ARB_RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ARB_RESP: begin
                last_d  = owner_q;
                state_d = ARB_IDLE;
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge cpu_clk or negedge cpu_rst) begin
        if (!cpu_rst) begin
            state_q  <= ARB_IDLE;
            owner_q  <= M0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            cnt_q    <= '0;
            last_q   <= M1;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            // Per-master capture so each rdata holds its own last read.
            if (cap_en && owner_q == M0) rdata0_q <= bus_rdata;
            if (cap_en && owner_q == M1) rdata1_q <= bus_rdata;
        end
    end

    logic in_issue;
    logic in_resp;

    assign in_issue = (state_q == ARB_ISSUE);
    assign in_resp  = (state_q == ARB_RESP);

    assign m0_gnt    = in_issue & (owner_q == M0);
    assign m1_gnt    = in_issue & (owner_q == M1);
    assign m0_rvalid = in_resp  & (owner_q == M0);
    assign m1_rvalid = in_resp  & (owner_q == M1);
    assign m0_rdata  = rdata0_q;
    assign m1_rdata  = rdata1_q;

    assign bus_en    = in_issue;
    assign bus_we    = in_issue & we_q;
    assign bus_addr  = in_issue ? addr_q  : '0;
    assign bus_wdata = in_issue ? wdata_q : '0;
    assign busy      = (state_q != ARB_IDLE);

endmodule

// File: tb/tb_dbus_arbiter.sv
// tb_dbus_arbiter: scoreboard bench, two arbiter instances.
// Instance 0: RD_LAT=2 round-robin. Instance 1: RD_LAT=1 fixed priority.
module tb_dbus_arbiter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic        m0_req[2], m0_we[2], m1_req[2], m1_we[2];
    logic [31:0] m0_addr[2], m0_wdata[2], m1_addr[2], m1_wdata[2];
    logic        m0_gnt[2], m0_rvalid[2], m1_gnt[2], m1_rvalid[2];
    logic [31:0] m0_rdata[2], m1_rdata[2];
    logic        bus_en[2], bus_we[2], busy[2];
    logic [31:0] bus_addr[2], bus_wdata[2], bus_rdata[2];

    dbus_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(2), .ARB_MODE(0)) u_dut_a (
        .cpu_clk(clk), .cpu_rst(rst_n),
        .m0_req(m0_req[0]), .m0_we(m0_we[0]), .m0_addr(m0_addr[0]),
        .m0_wdata(m0_wdata[0]), .m0_gnt(m0_gnt[0]), .m0_rvalid(m0_rvalid[0]),
        .m0_rdata(m0_rdata[0]),
        .m1_req(m1_req[0]), .m1_we(m1_we[0]), .m1_addr(m1_addr[0]),
        .m1_wdata(m1_wdata[0]), .m1_gnt(m1_gnt[0]), .m1_rvalid(m1_rvalid[0]),
        .m1_rdata(m1_rdata[0]),
        .bus_en(bus_en[0]), .bus_we(bus_we[0]), .bus_addr(bus_addr[0]),
        .bus_wdata(bus_wdata[0]), .bus_rdata(bus_rdata[0]), .busy(busy[0])
    );

    dbus_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(1), .ARB_MODE(1)) u_dut_b (
        .cpu_clk(clk), .cpu_rst(rst_n),
        .m0_req(m0_req[1]), .m0_we(m0_we[1]), .m0_addr(m0_addr[1]),
        .m0_wdata(m0_wdata[1]), .m0_gnt(m0_gnt[1]), .m0_rvalid(m0_rvalid[1]),
        .m0_rdata(m0_rdata[1]),
        .m1_req(m1_req[1]), .m1_we(m1_we[1]), .m1_addr(m1_addr[1]),
        .m1_wdata(m1_wdata[1]), .m1_gnt(m1_gnt[1]), .m1_rvalid(m1_rvalid[1]),
        .m1_rdata(m1_rdata[1]),
        .bus_en(bus_en[1]), .bus_we(bus_we[1]), .bus_addr(bus_addr[1]),
        .bus_wdata(bus_wdata[1]), .bus_rdata(bus_rdata[1]), .busy(busy[1])
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     tag, got, exp, cyc);
        end
    endtask

    typedef struct {
        int          d;
        int          m;
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
    } exp_t;

    exp_t gq[$];
    exp_t rq[$];

    function automatic logic [31:0] rd_model(input logic [31:0] a);
        return a ^ 32'hDEAD_BEAF;
    endfunction

    task automatic exp_g(input int d, input int m, input logic we,
                         input logic [31:0] a, input logic [31:0] wd);
        exp_t e;
        e.d = d; e.m = m; e.we = we; e.addr = a; e.data = wd;
        gq.push_back(e);
        if (!we) begin
            e.data = rd_model(a);
            rq.push_back(e);
        end
    endtask

    function automatic int find_g(input int d);
        foreach (gq[i]) if (gq[i].d == d) return i;
        return -1;
    endfunction

    function automatic int find_r(input int d);
        foreach (rq[i]) if (rq[i].d == d) return i;
        return -1;
    endfunction

    int          due[2] = '{-1, -1};
    int          cd[2]  = '{0, 0};
    logic [31:0] pend[2];

    task automatic mon(input int d, input int lat);
        int   idx;
        exp_t e;
        logic g0, g1, v0, v1;
        g0 = m0_gnt[d]; g1 = m1_gnt[d];
        v0 = m0_rvalid[d]; v1 = m1_rvalid[d];
        if (!rst_n) begin
            due[d] = -1;
            cd[d] = 0;
            bus_rdata[d] = 32'h0;
        end else begin
            bus_rdata[d] = 32'hBAD0_0000 | 32'(cyc);
            if (cd[d] > 0) begin
                cd[d]--;
                if (cd[d] == 0) bus_rdata[d] = pend[d];
            end
            if (bus_en[d] && !bus_we[d]) begin
                cd[d] = lat;
                pend[d] = rd_model(bus_addr[d]);
            end
            if (g0 | g1) begin
                idx = find_g(d);
                if (idx < 0) begin
                    chk($sformatf("unexp_gnt%0d", d), {g1, g0}, 0);
                end else begin
                    e = gq[idx];
                    gq.delete(idx);
                    chk("gnt_m", {g1, g0}, (e.m == 1) ? 2'b10 : 2'b01);
                    chk("bus_en", bus_en[d], 1);
                    chk("bus_we", bus_we[d], e.we);
                    chk("bus_addr", bus_addr[d], e.addr);
                    if (e.we) chk("bus_wdata", bus_wdata[d], e.data);
                    else due[d] = cyc + lat + 1;
                end
            end else begin
                chk("bus_idle_a", {bus_en[d], bus_we[d], bus_addr[d]}, 0);
                chk("bus_idle_w", bus_wdata[d], 0);
            end
            if (v0 | v1) begin
                idx = find_r(d);
                if (idx < 0) begin
                    chk($sformatf("unexp_rv%0d", d), {v1, v0}, 0);
                end else begin
                    e = rq[idx];
                    rq.delete(idx);
                    chk("rv_m", {v1, v0}, (e.m == 1) ? 2'b10 : 2'b01);
                    chk("rv_cyc", cyc, due[d]);
                    chk("rdata", v1 ? m1_rdata[d] : m0_rdata[d], e.data);
                end
                due[d] = -1;
            end else if (due[d] >= 0 && cyc > due[d]) begin
                chk("rv_late", cyc, due[d]);
                due[d] = -1;
            end
        end
    endtask

    always @(negedge clk) begin
        mon(0, 2);
        mon(1, 1);
    end

    task automatic set_req(input int d, input int m, input logic r);
        if (m == 0) m0_req[d] = r;
        else m1_req[d] = r;
    endtask

    task automatic drive(input int d, input int m, input logic we,
                         input logic [31:0] a, input logic [31:0] wd);
        bit got = 0;
        if (m == 0) begin
            m0_we[d] = we; m0_addr[d] = a; m0_wdata[d] = wd;
        end else begin
            m1_we[d] = we; m1_addr[d] = a; m1_wdata[d] = wd;
        end
        set_req(d, m, 1'b1);
        for (int i = 0; i < 64 && !got; i++) begin
            @(negedge clk);
            if ((m == 0 && m0_gnt[d]) || (m == 1 && m1_gnt[d])) got = 1;
        end
        set_req(d, m, 1'b0);
        if (!got) chk("gnt_timeout", 0, 1);
    endtask

    task automatic contend(input int d, input int n);
        int k = 0;
        m0_we[d] = 1; m0_addr[d] = 32'h1000; m0_wdata[d] = 32'hA0A0_A0A0;
        m1_we[d] = 1; m1_addr[d] = 32'h2000; m1_wdata[d] = 32'hB1B1_B1B1;
        m0_req[d] = 1; m1_req[d] = 1;
        for (int i = 0; i < 64 && k < n; i++) begin
            @(negedge clk);
            if (m0_gnt[d] | m1_gnt[d]) k++;
        end
        m0_req[d] = 0; m1_req[d] = 0;
        if (k < n) chk("contend_timeout", k, n);
    endtask

    task automatic chk_rst(input string tag, input int d);
        chk({tag, "_ctl"}, {m0_gnt[d], m1_gnt[d], m0_rvalid[d], m1_rvalid[d],
                            bus_en[d], bus_we[d], busy[d]}, 0);
        chk({tag, "_rd"}, {m0_rdata[d], m1_rdata[d]}, 0);
        chk({tag, "_bus"}, {bus_addr[d], bus_wdata[d]}, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int last;
        int n;
        for (int d = 0; d < 2; d++) begin
            m0_req[d] = 0; m0_we[d] = 0; m0_addr[d] = 0; m0_wdata[d] = 0;
            m1_req[d] = 0; m1_we[d] = 0; m1_addr[d] = 0; m1_wdata[d] = 0;
        end
        repeat (3) @(negedge clk);
        chk_rst("rst0_a", 0);
        chk_rst("rst0_b", 1);
        rst_n = 1;
        @(negedge clk);

        exp_g(0, 0, 1, 32'hFFFF_F000, 32'h1234_5678);
        m0_we[0] = 1; m0_addr[0] = 32'hFFFF_F000; m0_wdata[0] = 32'h1234_5678;
        m0_req[0] = 1;
        @(negedge clk);
        chk("wr_gnt", {m0_gnt[0], m1_gnt[0], busy[0]}, 3'b101);
        m0_req[0] = 0;
        @(negedge clk);
        chk("wr_busy_low", busy[0], 0);

        exp_g(0, 1, 0, 32'h0000_0040, 32'h0);
        drive(0, 1, 0, 32'h0000_0040, 32'h0);
        repeat (6) @(negedge clk);
        chk("m1_rdata_hold", m1_rdata[0], 32'hDEAD_BEEF);
        chk("m0_rdata_keep", m0_rdata[0], 32'h0);

        exp_g(0, 0, 0, 32'h0000_0300, 32'h0);
        void'(rq.pop_back());
        drive(0, 0, 0, 32'h0000_0300, 32'h0);
        @(negedge clk);
        rst_n = 0;
        #1;
        chk_rst("rst_wait", 0);
        @(negedge clk);
        chk_rst("rst_hold", 0);
        rst_n = 1;
        @(negedge clk);

        exp_g(0, 0, 1, 32'h10, 32'h11);
        exp_g(0, 1, 1, 32'h20, 32'h22);
        fork
            drive(0, 0, 1, 32'h10, 32'h11);
            drive(0, 1, 1, 32'h20, 32'h22);
        join

        for (int i = 0; i < 4; i++) begin
            if (i % 2 == 0) exp_g(0, 0, 1, 32'h1000, 32'hA0A0_A0A0);
            else exp_g(0, 1, 1, 32'h2000, 32'hB1B1_B1B1);
        end
        contend(0, 4);
        @(negedge clk);

        exp_g(0, 0, 0, 32'h0000_0100, 32'h0);
        drive(0, 0, 0, 32'h0000_0100, 32'h0);
        @(negedge clk);
        m1_we[0] = 1; m1_addr[0] = 32'h0000_0BAD; m1_req[0] = 1;
        @(negedge clk);
        m1_req[0] = 0;
        repeat (6) @(negedge clk);

        for (int i = 0; i < 4; i++) exp_g(1, 0, 1, 32'h1000, 32'hA0A0_A0A0);
        contend(1, 4);
        @(negedge clk);

        for (int i = 0; i < 3; i++) exp_g(1, 0, 0, 32'h200 + 32'(4 * i), 32'h0);
        m0_we[1] = 0; m0_addr[1] = 32'h200; m0_req[1] = 1;
        n = 0;
        last = 0;
        for (int i = 0; i < 60 && n < 3; i++) begin
            @(negedge clk);
            if (m0_gnt[1]) begin
                if (n > 0) chk("b2b_gap", cyc - last, 4);
                last = cyc;
                n++;
                m0_addr[1] = m0_addr[1] + 32'h4;
            end
        end
        m0_req[1] = 0;
        if (n < 3) chk("b2b_timeout", n, 3);

        repeat (10) @(negedge clk);
        chk("gq_left", gq.size(), 0);
        chk("rq_left", rq.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
